// File: rtl/hazard_ctrl.sv
// Decode-side hazard unit: in-flight rd shadow, stall/flush/bubble controls, registered forwarding selects.
// Build option FORWARDING_EN: load-use stalls plus forwarding; otherwise stall on any RAW until writer is in WB.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             ex_redirect_i,
    output logic             pc_stall_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } slot_t;

    slot_t            ex_q, ex_d, mem_q, wb_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             ex_m1, ex_m2, mem_m1, mem_m2;
    logic             hz, stall, advance;

    function automatic logic match(input slot_t s, input logic [4:0] rs, input logic use_rs);
        return s.v & s.wr & (s.rd != 5'd0) & use_rs & (s.rd == rs);
    endfunction

    assign ex_m1  = match(ex_q,  id_rs1_i, id_use_rs1_i);
    assign ex_m2  = match(ex_q,  id_rs2_i, id_use_rs2_i);
    assign mem_m1 = match(mem_q, id_rs1_i, id_use_rs1_i);
    assign mem_m2 = match(mem_q, id_rs2_i, id_use_rs2_i);

`ifdef FORWARDING_EN
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    assign hz = (ex_m1 | ex_m2) & ex_q.ld;

    // EX slot wins: it holds the younger write to the same register
    always_comb begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (advance) begin
            if (ex_m1)       fwd_a_d = 2'b01;
            else if (mem_m1) fwd_a_d = 2'b10;
            if (ex_m2)       fwd_b_d = 2'b01;
            else if (mem_m2) fwd_b_d = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_o = fwd_a_q;
    assign fwd_b_o = fwd_b_q;
`else
    assign hz      = ex_m1 | ex_m2 | mem_m1 | mem_m2;
    assign fwd_a_o = 2'b00;
    assign fwd_b_o = 2'b00;
`endif

    assign stall   = id_valid_i & ~ex_redirect_i & hz;
    assign advance = id_valid_i & ~ex_redirect_i & ~stall;

    always_comb begin
        ex_d = '0;
        if (advance) begin
            ex_d.v  = 1'b1;
            ex_d.rd = id_rd_i;
            ex_d.wr = id_regwrite_i;
            ex_d.ld = id_memread_i;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (ex_redirect_i && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // WB slot is tracked but never hazards: the regfile writes before it reads
    logic unused_slot_bits;
    assign unused_slot_bits = ^{wb_q, mem_q.ld, ex_q.ld};

    // Reset fills the pipe with NOPs; a redirect overrides a same-cycle stall
    always_comb begin
        pc_stall_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        if (!rstn || ex_redirect_i) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (stall) begin
            pc_stall_o    = 1'b1;
            ifid_stall_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Decode-side producer of the ID/EX pipeline-register controls.
- Keeps a shadow of the destination registers in flight (EX, MEM, WB slots) and compares them against the instruction in ID.
- Generates PC/IF-ID stall, IF-ID flush and ID/EX bubble, plus registered forwarding selects that line up with the ID/EX outputs.
- Handles load-use stalls and EX-resolved redirects, and keeps saturating stall/flush event counters.

Parameters:
- CNT_W, 16, width of the stall and flush event counters (saturating).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- id_valid_i  in  1  valid instruction in ID
- id_rs1_i  in  5  source reg 1 of ID instruction
- id_rs2_i  in  5  source reg 2 of ID instruction
- id_use_rs1_i  in  1  ID instruction reads rs1
- id_use_rs2_i  in  1  ID instruction reads rs2
- id_rd_i  in  5  destination reg of ID instruction
- id_regwrite_i  in  1  ID instruction writes rd
- id_memread_i  in  1  ID instruction is a load
- ex_redirect_i  in  1  branch/jump taken, resolved in EX this cycle
- pc_stall_o  out  1  hold PC
- ifid_stall_o  out  1  hold IF/ID register
- ifid_flush_o  out  1  clear IF/ID register
- idex_bubble_o  out  1  load NOP controls into ID/EX (RegWrite=MemWrite=MemRead=0)
- fwd_a_o  out  2  operand-A select for the instruction now in EX: 00 regfile, 01 EX/MEM, 10 MEM/WB
- fwd_b_o  out  2  operand-B select, same encoding
- stall_cnt_o  out  CNT_W  stall cycles counted
- flush_cnt_o  out  CNT_W  redirect flushes counted

Behaviour:
- Shadow slots EX, MEM and WB each hold {valid, rd, wr, ld}. Every cycle they shift MEM<=EX and WB<=MEM.
- EX slot loads the ID fields when id_valid_i=1 and neither stall nor redirect is active; otherwise it loads empty (valid=0).
- match(slot, rs, use) = slot.valid & slot.wr & slot.rd!=0 & use & slot.rd==rs, evaluated for rs1 and rs2. Register x0 never matches.
- The WB slot never causes a hazard: the regfile is write-first.
- stall (combinational) = id_valid_i & !ex_redirect_i & hz. hz depends on the build (see Optional Feature).
- When stall=1: pc_stall_o=ifid_stall_o=idex_bubble_o=1 and ifid_flush_o=0.
- When ex_redirect_i=1: ifid_flush_o=1, idex_bubble_o=1, both stalls 0. Redirect wins over any stall in the same cycle.
- Otherwise all four control outputs are 0.
- fwd_a_o/fwd_b_o are registered, one-cycle latency, so they are valid in the same cycle the ID/EX outputs are.
  - On an advancing cycle (ID instruction enters EX): fwd <= EX-slot match ? 01 : MEM-slot match ? 10 : 00. The EX slot has priority because it holds the newer value.
  - On a stall, redirect or !id_valid_i cycle: fwd <= 00.
- stall_cnt_o +1 on every cycle with stall=1. flush_cnt_o +1 on every cycle with ex_redirect_i=1. Both hold at all-ones (saturate, never wrap).
- While rstn=0 (synchronous), the following apply at the clock edge:
  - All slots go invalid; fwd_a_o=fwd_b_o=00; counters go to 0.
  - Combinational outputs are forced to pc_stall_o=ifid_stall_o=0 and ifid_flush_o=idex_bubble_o=1 so the pipeline fills with NOPs.
- Deasserting reset mid-stream needs no recovery: slots start empty, so there is no false hazard on the first cycle.

Optional Feature:
- Macro FORWARDING_EN.
- Defined: hz = match on the EX slot where EX.ld=1 (load-use only) for rs1 or rs2. Gives a 1-cycle load-use stall; fwd outputs are driven as above.
- Undefined: hz = any match on the EX or MEM slot for rs1 or rs2. A RAW dependency stalls until the writer reaches WB (up to 2 cycles). fwd_a_o/fwd_b_o are tied to 00.

Test Plan:
- Reset: rstn=0 for 2 cycles -> stall_cnt_o=flush_cnt_o=0, fwd=00, ifid_flush_o=idex_bubble_o=1. After release with no valid ID, all control outputs are 0.
- FORWARDING_EN, lw x5 followed by add x6,x5,x1 -> stall and bubble for exactly 1 cycle, stall_cnt_o=1. The cycle after the add enters EX, fwd_a_o=10.
- FORWARDING_EN, add x3 followed by sub x4,x1,x3 -> no stall; fwd_b_o=01 in the cycle sub is in EX.
- Writer with rd=x0 (regwrite=1), then a reader of x0 -> no stall, fwd 00, in both builds.
- ex_redirect_i=1 in the same cycle as a load-use match -> ifid_flush_o=1, idex_bubble_o=1, pc_stall_o=0; flush_cnt_o +1, stall_cnt_o unchanged.
- FORWARDING_EN undefined, add x3 followed by a reader of x3 -> exactly 2 stall cycles, stall_cnt_o=2. With CNT_W=2 and 5 stalls -> stall_cnt_o=3 (saturated).
